// File: rtl/block_data_memory.sv
// block_data_memory
// Backing data memory behind the data cache: 64 blocks x 32 bits, word
// (block) addressed, responding to the cache controller's block read/write
// requests. Every access takes LATENCY busy cycles plus one completion cycle.
// mem_busywait rises combinationally on a legal request in IDLE and then
// follows the FSM state.
//
// Optional feature macro: DMEM_CLEAR_ON_RESET_EN
//   defined   : reset_n low also clears all 64 blocks to zero.
//   undefined : array contents survive reset (unknown until first written).

module block_data_memory #(
  parameter int LATENCY = 5
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [5:0]  mem_address,
  input  logic [31:0] mem_writedata,
  output logic [31:0] mem_readdata,
  output logic        mem_busywait
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Terminal count of the latency counter (LATENCY is 1..15).
  localparam logic [3:0] LAT_C = 4'(LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_array [64];

  logic        req_legal;
  logic        access_fire;
  logic        mem_we;
  logic        mem_re;

  // Decode request legality and the single edge where the access happens.
  always_comb begin
    req_legal   = mem_read ^ mem_write;
    access_fire = (state_q == ST_BUSY) && (cnt_q == LAT_C);
    mem_we      = access_fire && op_wr_q;
    mem_re      = access_fire && !op_wr_q;
  end

  // Next-state logic for the access FSM, counter and latched request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_legal) begin
          state_d = ST_BUSY;
          cnt_d   = 4'd1;
          op_wr_d = mem_write;
          addr_d  = mem_address;
          wdata_d = mem_writedata;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      ST_BUSY: begin
        if (cnt_q == LAT_C) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
          if (mem_re) begin
            rdata_d = mem_array[addr_q];
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = ST_BUSY;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter, latched request and registered read data.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      addr_q  <= 6'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Busywait: combinational from the request only while idle (and never
  // during reset), otherwise a decode of the state register.
  always_comb begin
    mem_busywait = 1'b0;
    case (state_q)
      ST_IDLE: mem_busywait = req_legal && reset_n;
      ST_BUSY: mem_busywait = 1'b1;
      ST_DONE: mem_busywait = 1'b0;
      default: mem_busywait = 1'b0;
    endcase
  end

  assign mem_readdata = rdata_q;

`ifdef DMEM_CLEAR_ON_RESET_EN
  // Storage array, cleared to zero while reset is asserted.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) begin
        mem_array[i] <= 32'd0;
      end
    end else if (mem_we) begin
      mem_array[addr_q] <= wdata_q;
    end else begin
      mem_array[addr_q] <= mem_array[addr_q];
    end
  end
`else
  // Storage array, retained across reset; an in-flight write is lost
  // because reset forces the FSM out of BUSY before the write edge.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_array[addr_q] <= wdata_q;
    end
  end
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// Self-checking bench for block_data_memory: three instances (LATENCY 5, 1,
// 15) driven with directed and $urandom stimulus, compared against a simple
// array model of the memory contents and last-read value.

`timescale 1ns/1ps

module tb_block_data_memory;

  localparam int NI = 3;
  localparam int LATS [NI] = '{5, 1, 15};

  logic        clk;
  logic        rstn  [NI];
  logic        rd    [NI];
  logic        wr    [NI];
  logic [5:0]  addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] dout  [NI];
  logic        busy  [NI];

  int errs;
  int checks;
  int cyc;

  logic [31:0] mdl_mem [NI][64];
  logic [31:0] mdl_rd  [NI];

  block_data_memory #(.LATENCY(5)) u_dut0 (
    .CLK(clk), .reset_n(rstn[0]), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_address(addr[0]), .mem_writedata(wdata[0]),
    .mem_readdata(dout[0]), .mem_busywait(busy[0]));

  block_data_memory #(.LATENCY(1)) u_dut1 (
    .CLK(clk), .reset_n(rstn[1]), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_address(addr[1]), .mem_writedata(wdata[1]),
    .mem_readdata(dout[1]), .mem_busywait(busy[1]));

  block_data_memory #(.LATENCY(15)) u_dut2 (
    .CLK(clk), .reset_n(rstn[2]), .mem_read(rd[2]), .mem_write(wr[2]),
    .mem_address(addr[2]), .mem_writedata(wdata[2]),
    .mem_readdata(dout[2]), .mem_busywait(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle index, advanced on each rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One access on instance k, started right after a rising edge.
  // mode 0: plain; 1: change address/data in C2; 2: drop the request in C2.
  task automatic access(input int k, input bit is_wr, input logic [5:0] a,
                        input logic [31:0] d, input int mode, output int done_cyc);
    int busy_n;
    int c;
    bit done;
    busy_n   = 0;
    c        = 0;
    done     = 1'b0;
    done_cyc = -1;
    addr[k]  = a;
    wdata[k] = d;
    rd[k]    = !is_wr;
    wr[k]    = is_wr;
    while (!done && c < 40) begin
      @(negedge clk);
      if (busy[k]) busy_n++;
      else begin
        done     = 1'b1;
        done_cyc = cyc;
      end
      if (!done) begin
        @(posedge clk); #1;
        c++;
        if (c == 2 && mode == 1) begin
          addr[k]  = 6'd4;
          wdata[k] = $urandom;
        end
        if (c == 2 && mode == 2) begin
          rd[k] = 1'b0;
          wr[k] = 1'b0;
        end
      end
    end
    check_value("busy_cycles", 32'(busy_n), 32'(LATS[k] + 1));
    if (is_wr) mdl_mem[k][a] = d;
    else       mdl_rd[k]     = mdl_mem[k][a];
    check_value(is_wr ? "rdata_after_wr" : "rdata_after_rd", dout[k], mdl_rd[k]);
    @(posedge clk); #1;
    rd[k] = 1'b0;
    wr[k] = 1'b0;
  endtask

  initial begin
    int dc;
    int dc2;
    int start;
    logic [5:0]  ra;
    logic [31:0] prior;
    errs   = 0;
    checks = 0;
    cyc    = 0;
    for (int k = 0; k < NI; k++) begin
      rstn[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
      addr[k] = 6'd0; wdata[k] = 32'd0; mdl_rd[k] = 32'd0;
    end
    rd[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // reset state, including busywait held low with a request pending
    for (int k = 0; k < NI; k++) begin
      check_value("reset_rdata", dout[k], 32'd0);
      check_value("reset_busy", 32'(busy[k]), 32'd0);
    end
    @(posedge clk); #1;
    rd[0] = 1'b0;
    for (int k = 0; k < NI; k++) rstn[k] = 1'b1;
    @(posedge clk); #1;

    // prefill every block of every instance with random data
    for (int k = 0; k < NI; k++)
      for (int a = 0; a < 64; a++)
        access(k, 1'b1, 6'(a), $urandom, 0, dc);

    // write/read of a known pattern at every latency
    for (int k = 0; k < NI; k++) begin
      access(k, 1'b1, 6'd9, 32'hDEADBEEF, 0, dc);
      access(k, 1'b0, 6'd9, 32'd0, 0, dc);
      check_value("deadbeef", dout[k], 32'hDEADBEEF);
    end

    // random mix of reads and writes
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(NI - 1);
      access(k, 1'($urandom_range(1)), 6'($urandom), $urandom, 0, dc);
    end

    // address change during BUSY: block 3 is still returned
    access(0, 1'b0, 6'd3, 32'd0, 1, dc);
    // request dropped during BUSY: access still completes
    access(0, 1'b0, 6'd5, 32'd0, 2, dc);
    access(2, 1'b1, 6'd6, 32'hA5A5_0F0F, 2, dc);
    access(2, 1'b0, 6'd6, 32'd0, 0, dc);

    // simultaneous read and write requests are ignored
    addr[1]  = 6'd7;
    wdata[1] = ~mdl_mem[1][7];
    rd[1]    = 1'b1;
    wr[1]    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_value("both_req_busy", 32'(busy[1]), 32'd0);
      @(posedge clk); #1;
    end
    rd[1] = 1'b0;
    wr[1] = 1'b0;
    check_value("both_req_rdata", dout[1], mdl_rd[1]);
    @(posedge clk); #1;
    access(1, 1'b0, 6'd7, 32'd0, 0, dc);

    // reset in C3 of a write to block 20
    prior    = mdl_mem[0][20];
    addr[0]  = 6'd20;
    wdata[0] = 32'h12345678;
    wr[0]    = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rstn[0] = 1'b0;
    #1;
    check_value("rst_mid_busy", 32'(busy[0]), 32'd0);
    check_value("rst_mid_rdata", dout[0], 32'd0);
    @(negedge clk);
    check_value("rst_held_busy", 32'(busy[0]), 32'd0);
    @(posedge clk); #1;
    wr[0]     = 1'b0;
    mdl_rd[0] = 32'd0;
`ifdef DMEM_CLEAR_ON_RESET_EN
    for (int a = 0; a < 64; a++) mdl_mem[0][a] = 32'd0;
    prior = 32'd0;
`endif
    @(posedge clk); #1;
    rstn[0] = 1'b1;
    @(posedge clk); #1;
    access(0, 1'b0, 6'd20, 32'd0, 0, dc);
    check_value("rst_prior_20", dout[0], prior);
`ifdef DMEM_CLEAR_ON_RESET_EN
    // repopulate so the back-to-back read has defined data
    access(0, 1'b1, 6'd63, $urandom, 0, dc);
`endif

    // back-to-back: write 0 then read 63 with no gap in the request
    ra    = 6'd63;
    start = cyc;
    access(0, 1'b1, 6'd0, $urandom, 0, dc);
    access(0, 1'b0, ra, 32'd0, 0, dc2);
    check_value("b2b_write_done", 32'(dc - start), 32'd6);
    check_value("b2b_read_done", 32'(dc2 - start), 32'd13);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
